// File: rtl/ps2_kb_pkg.sv
// rtl/ps2_kb_pkg.sv - shared scan codes, parser states and event format for the PS/2 key event path
package ps2_kb_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_EXT     = 2'd1;
  localparam logic [1:0] ST_BRK     = 2'd2;
  localparam logic [1:0] ST_EXT_BRK = 2'd3;

  typedef enum logic [1:0] {
    LANE_NONE = 2'd0,
    LANE_A    = 2'd1,
    LANE_S    = 2'd2,
    LANE_D    = 2'd3
  } lane_t;

  localparam int EVT_W = 3;

  typedef struct packed {
    lane_t key;
    logic  press;
  } evt_t;

  function automatic lane_t lane_of(input logic [7:0] code);
    case (code)
      SC_A:    lane_of = LANE_A;
      SC_S:    lane_of = LANE_S;
      SC_D:    lane_of = LANE_D;
      default: lane_of = LANE_NONE;
    endcase
  endfunction

  // One-hot position of a lane inside the held vector (bit0=A).
  function automatic logic [2:0] lane_mask(input lane_t lane);
    case (lane)
      LANE_A:  lane_mask = 3'b001;
      LANE_S:  lane_mask = 3'b010;
      LANE_D:  lane_mask = 3'b100;
      default: lane_mask = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// rtl/ps2_evt_fifo.sv - first-word-fall-through event FIFO; a push while full with no pop is dropped
import ps2_kb_pkg::*;

module ps2_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = EVT_W
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         drop
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         full;
  logic         do_pop;
  logic         do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;
  assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ps2_key_event_ctrl.sv
// rtl/ps2_key_event_ctrl.sv - PS/2 receiver handshake, make/break/extended parser and lane press/release events
import ps2_kb_pkg::*;

module ps2_key_event_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1_000_000,
  parameter int TO_W       = 20
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] scan_code,
  input  logic       scan_ready,
  output logic       read,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [1:0] evt_key,
  output logic       evt_press,
  output logic [2:0] held,
  output logic       overflow
);

  logic            sync1;
  logic            rdy_s;
  logic            ack_pending;
  logic [7:0]      code_r;
  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [TO_W-1:0] to_cnt;
  logic            timed_out;
  lane_t           lane;
  logic [2:0]      mask;
  logic            make;
  logic            brk;
  logic            held_hit;
  logic            push;
  logic [2:0]      held_nxt;
  evt_t            push_evt;
  evt_t            head_evt;
  logic            fifo_empty;
  logic            drop;

  // ack_pending blocks re-capture until the receiver has visibly dropped scan_ready.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1       <= 1'b0;
      rdy_s       <= 1'b0;
      ack_pending <= 1'b0;
      read        <= 1'b0;
      code_r      <= 8'h00;
    end else begin
      sync1 <= scan_ready;
      rdy_s <= sync1;
      read  <= 1'b0;
      if (!rdy_s) begin
        ack_pending <= 1'b0;
      end else if (!ack_pending) begin
        code_r      <= scan_code;
        ack_pending <= 1'b1;
        read        <= 1'b1;
      end
    end
  end

  assign lane      = lane_of(code_r);
  assign mask      = lane_mask(lane);
  assign held_hit  = |(held & mask);
  assign timed_out = (state != ST_IDLE) && (to_cnt == TO_W'(TIMEOUT));

  // code_r is parsed in the cycle read is high.
  always_comb begin
    state_nxt = state;
    make      = 1'b0;
    brk       = 1'b0;
    if (read) begin
      case (state)
        ST_IDLE: begin
          if (code_r == SC_EXT)         state_nxt = ST_EXT;
          else if (code_r == SC_BREAK)  state_nxt = ST_BRK;
          else                          make      = (lane != LANE_NONE);
        end
        ST_EXT:  state_nxt = (code_r == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
        ST_BRK: begin
          brk       = (lane != LANE_NONE);
          state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end else if (timed_out) begin
      state_nxt = ST_IDLE;
    end
  end

  // Repeats of a held key and breaks of a released key are swallowed here.
  assign push           = (make && !held_hit) || (brk && held_hit);
  assign push_evt.key   = lane;
  assign push_evt.press = make;

  always_comb begin
    held_nxt = held;
    if (push) held_nxt = make ? (held | mask) : (held & ~mask);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      to_cnt   <= '0;
      held     <= 3'b000;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      held     <= held_nxt;
      overflow <= overflow | drop;
      if (read || state == ST_IDLE || timed_out) to_cnt <= '0;
      else                                       to_cnt <= to_cnt + 1'b1;
    end
  end

  ps2_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (EVT_W)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .push_data (push_evt),
    .pop       (evt_ready),
    .head      (head_evt),
    .empty     (fifo_empty),
    .drop      (drop)
  );

  assign evt_valid = !fifo_empty;
  assign evt_key   = head_evt.key;
  assign evt_press = head_evt.press;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// tb/tb_ps2_key_event_ctrl.sv - directed bench with a byte-sequence model of lane events
module tb_ps2_key_event_ctrl;

  localparam int DEPTH = 4;
  localparam int TMO   = 40;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic       scan_ready = 1'b0;
  logic       evt_ready = 1'b0;
  logic       read;
  logic       evt_valid;
  logic [1:0] evt_key;
  logic       evt_press;
  logic [2:0] held;
  logic       overflow;

  int n_cmp = 0;
  int n_err = 0;

  logic [2:0] m_q[$];
  logic [7:0] m_pfx[$];
  logic [2:0] m_held = 3'b000;
  logic       m_ovf = 1'b0;
  int         idle_cyc = 0;
  bit         armed = 0;
  logic [2:0] popped[$];

  ps2_key_event_ctrl #(
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT    (TMO),
    .TO_W       (8)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .scan_code  (scan_code),
    .scan_ready (scan_ready),
    .read       (read),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_key    (evt_key),
    .evt_press  (evt_press),
    .held       (held),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic int lane_num(input logic [7:0] b);
    if (b == 8'h1C) return 1;
    if (b == 8'h1B) return 2;
    if (b == 8'h23) return 3;
    return 0;
  endfunction

  function automatic logic [2:0] get_popped(input int i);
    if (popped.size() > i) return popped[i];
    return 3'bxxx;
  endfunction

  task automatic model_event(input int ln, input bit press);
    logic [1:0] k;
    if (m_held[ln-1] == press) return;
    m_held[ln-1] = press;
    k = ln[1:0];
    if (m_q.size() < DEPTH) m_q.push_back({k, press});
    else m_ovf = 1'b1;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int ln;
    ln = lane_num(b);
    if (m_pfx.size() > 0 && idle_cyc > TMO + 1) m_pfx.delete();
    idle_cyc = 0;
    if (m_pfx.size() == 0) begin
      if (b == 8'hE0 || b == 8'hF0) m_pfx.push_back(b);
      else if (ln != 0) model_event(ln, 1'b1);
    end else if (m_pfx.size() == 1 && m_pfx[0] == 8'hF0) begin
      if (ln != 0) model_event(ln, 1'b0);
      m_pfx.delete();
    end else if (m_pfx.size() == 1 && b == 8'hF0) begin
      m_pfx.push_back(b);
    end else begin
      m_pfx.delete();
    end
  endtask

  always @(negedge clk) begin
    logic [2:0] h;
    if (armed) begin
      check("evt_valid", evt_valid, m_q.size() != 0);
      if (m_q.size() != 0) begin
        h = m_q[0];
        check("evt_key", evt_key, h[2:1]);
        check("evt_press", evt_press, h[0]);
      end
      check("held", held, m_held);
      check("overflow", overflow, m_ovf);
    end
    if (!resetn) begin
      m_q.delete();
      m_pfx.delete();
      m_held = 3'b000;
      m_ovf = 1'b0;
      idle_cyc = 0;
      armed = 1;
    end else if (armed) begin
      idle_cyc++;
      if (evt_valid && evt_ready) popped.push_back({evt_key, evt_press});
      if (evt_ready && m_q.size() != 0) void'(m_q.pop_front());
      if (read) model_byte(scan_code);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1);
    resetn = 1'b0;
    step(1);
    resetn = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int lat;
    int extra;
    lat = 0;
    extra = 0;
    step(1);
    scan_code = b;
    scan_ready = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      if (read) begin
        lat = i;
        break;
      end
    end
    check("read_latency", lat, 3);
    scan_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      if (read) extra++;
    end
    check("read_once", extra, 0);
  endtask

  initial begin
    int nreads;
    int first;
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nreads;
    int first;
    step(2);
    resetn = 1'b1;

    // Test 1: level held high for 100 cycles is acknowledged once
    do_reset();
    check("rst_read", read, 0);
    check("rst_evt_valid", evt_valid, 0);
    check("rst_evt_key", evt_key, 0);
    check("rst_evt_press", evt_press, 0);
    check("rst_held", held, 0);
    check("rst_overflow", overflow, 0);
    nreads = 0;
    first = 0;
    scan_code = 8'h1C;
    scan_ready = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      step(1);
      if (read) begin
        nreads++;
        if (first == 0) first = i;
      end
    end
    scan_ready = 1'b0;
    check("t1_reads", nreads, 1);
    check("t1_first_read", first, 3);
    step(4);
    check("t1_valid", evt_valid, 1);
    check("t1_key", evt_key, 1);
    check("t1_press", evt_press, 1);
    check("t1_held", held, 3'b001);
    evt_ready = 1'b1;
    step(2);
    check("t1_drained", evt_valid, 0);

    // Test 2: typematic repeats suppressed
    do_reset();
    popped.delete();
    send_byte(8'h1C);
    send_byte(8'h1C);
    send_byte(8'h1C);
    send_byte(8'hF0);
    send_byte(8'h1C);
    step(3);
    check("t2_count", popped.size(), 2);
    check("t2_ev0", get_popped(0), 3'b011);
    check("t2_ev1", get_popped(1), 3'b010);
    check("t2_held", held, 3'b000);

    // Test 3: extended sequences never produce lane events
    do_reset();
    popped.delete();
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h1C);
    send_byte(8'hE0);
    send_byte(8'h1B);
    step(3);
    check("t3_none", popped.size(), 0);
    check("t3_held0", held, 3'b000);
    send_byte(8'h1B);
    step(3);
    check("t3_count", popped.size(), 1);
    check("t3_ev0", get_popped(0), 3'b101);
    check("t3_held", held, 3'b010);

    // Test 4: stale break prefix times out
    do_reset();
    popped.delete();
    send_byte(8'hF0);
    step(TMO + 5);
    send_byte(8'h23);
    step(3);
    check("t4_count", popped.size(), 1);
    check("t4_ev0", get_popped(0), 3'b111);
    check("t4_held", held, 3'b100);

    // Test 5: six events into a four-entry FIFO with no consumer
    do_reset();
    popped.delete();
    evt_ready = 1'b0;
    send_byte(8'h1C);
    send_byte(8'h1B);
    send_byte(8'h23);
    send_byte(8'hF0);
    send_byte(8'h1C);
    send_byte(8'h1C);
    send_byte(8'hF0);
    send_byte(8'h1B);
    step(2);
    check("t5_overflow", overflow, 1);
    check("t5_held", held, 3'b101);
    check("t5_valid", evt_valid, 1);
    evt_ready = 1'b1;
    step(8);
    check("t5_pops", popped.size(), 4);
    check("t5_ev0", get_popped(0), 3'b011);
    check("t5_ev1", get_popped(1), 3'b101);
    check("t5_ev2", get_popped(2), 3'b111);
    check("t5_ev3", get_popped(3), 3'b010);
    check("t5_empty", evt_valid, 0);

    // Test 6: reset with two queued events and a partial prefix
    evt_ready = 1'b0;
    send_byte(8'h1B);
    send_byte(8'hF0);
    send_byte(8'h1C);
    send_byte(8'hF0);
    check("t6_pre_valid", evt_valid, 1);
    do_reset();
    popped.delete();
    check("t6_valid", evt_valid, 0);
    check("t6_overflow", overflow, 0);
    check("t6_held", held, 3'b000);
    check("t6_key", evt_key, 0);
    check("t6_press", evt_press, 0);
    evt_ready = 1'b1;
    send_byte(8'h1B);
    step(3);
    check("t6_count", popped.size(), 1);
    check("t6_ev0", get_popped(0), 3'b101);
    check("t6_held_s", held, 3'b010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
